dirty_line_fifo: RTL

- Multi-entry FIFO of evicted dirty D$ lines, sitting between dcache and write_buffer.
- dcache pushes victim lines. write_buffer pops one line at a time and bursts it over AXI3.
- dcache can query any resident line by label to read it back on a refill hit, or to merge a store into it before it leaves.

---
 rtl/dirty_line_fifo_pkg.sv | 29 ++
 rtl/dirty_line_fifo.sv | 109 ++++++++++
 2 files changed

// File: rtl/dirty_line_fifo_pkg.sv
// Shared cache-line definitions: line geometry constants, line/label/data/byte-enable
// types and a byte-merge helper used by the dirty line FIFO and dcache.
package dirty_line_fifo_pkg;

  localparam int unsigned CL_LINE_WIDTH  = 256;
  localparam int unsigned CL_BE_WIDTH    = CL_LINE_WIDTH / 8;
  localparam int unsigned CL_OFFSET_BITS = $clog2(CL_BE_WIDTH);
  localparam int unsigned CL_LABEL_WIDTH = 32 - CL_OFFSET_BITS;

  typedef logic [CL_LABEL_WIDTH-1:0] label_t;
  typedef logic [CL_LINE_WIDTH-1:0]  data_t;
  typedef logic [CL_BE_WIDTH-1:0]    be_t;

  typedef struct packed {
    label_t label;
    data_t  data;
  } line_t;

  // Byte i of the result comes from wdata where be[i] is set, else from data.
  function automatic data_t merge_bytes(input data_t data, input data_t wdata, input be_t be);
    data_t res;
    res = data;
    for (int unsigned i = 0; i < CL_BE_WIDTH; i++) begin
      if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dirty_line_fifo.sv
// FIFO of evicted dirty D$ lines between dcache and write_buffer, with a fully
// associative label lookup for refill read-back and byte-masked store merging.
module dirty_line_fifo
  import dirty_line_fifo_pkg::*;
#(
  parameter  int unsigned LINE_WIDTH  = CL_LINE_WIDTH,
  parameter  int unsigned LINE_DEPTH  = 8,
  localparam int unsigned LABEL_WIDTH = 32 - $clog2(LINE_WIDTH / 8),
  localparam int unsigned BE_WIDTH    = LINE_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] pline,
  input  logic                              push,
  output logic                              full,
  output logic                              pushed,
  output logic [LABEL_WIDTH+LINE_WIDTH-1:0] rline,
  input  logic                              pop,
  output logic                              empty,
  input  logic [LABEL_WIDTH-1:0]            query_label,
  output logic                              query_found,
  output logic                              query_on_pop,
  output logic [LINE_WIDTH-1:0]             query_rdata,
  input  logic [LINE_WIDTH-1:0]             query_wdata,
  input  logic [BE_WIDTH-1:0]               query_wbe,
  input  logic                              write,
  output logic                              written
);

  localparam int unsigned PW = $clog2(LINE_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LINE_DEPTH);

  logic [LABEL_WIDTH-1:0] label_q [LINE_DEPTH];
  logic [LINE_WIDTH-1:0]  data_q  [LINE_DEPTH];
  logic [LINE_DEPTH-1:0]  valid_q;
  logic [PW-1:0]          head_q;
  logic [PW-1:0]          tail_q;
  logic [CW-1:0]          count_q;

  logic [LINE_DEPTH-1:0]  match;
  logic [LINE_WIDTH-1:0]  merged;
  logic                   pop_en;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign pushed = push & ~full;
  assign pop_en = pop & ~empty;
  assign rline  = {label_q[head_q], data_q[head_q]};

  for (genvar i = 0; i < LINE_DEPTH; i++) begin : g_match
    assign match[i] = valid_q[i] & (label_q[i] == query_label);
  end

  // Labels are unique among valid entries, so OR-ing the gated data is a one-hot mux.
  always_comb begin
    query_rdata = '0;
    for (int unsigned i = 0; i < LINE_DEPTH; i++) begin
      if (match[i]) query_rdata = query_rdata | data_q[i];
    end
  end

  always_comb begin
    merged = query_rdata;
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      if (query_wbe[b]) merged[b*8 +: 8] = query_wdata[b*8 +: 8];
    end
  end

  assign query_found  = |match;
  assign query_on_pop = match[head_q] & pop_en;
  assign written      = write & query_found & ~query_on_pop;

  // A merge never targets tail on a push cycle: tail is invalid whenever not full.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int unsigned i = 0; i < LINE_DEPTH; i++) begin
        label_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      if (written) begin
        for (int unsigned i = 0; i < LINE_DEPTH; i++) begin
          if (match[i]) data_q[i] <= merged;
        end
      end
      if (pushed) begin
        label_q[tail_q] <= pline[LABEL_WIDTH+LINE_WIDTH-1 -: LABEL_WIDTH];
        data_q[tail_q]  <= pline[LINE_WIDTH-1:0];
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop_en) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({pushed, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
